// File: rtl/rx_pcs_pkg.sv
// Shared 10GBASE-R receive PCS definitions: block-lock states and sync-header helpers.
// Also used by the decoder and the BER monitor.
package rx_pcs_pkg;

    typedef enum logic [2:0] {
        LOCK_INIT,
        RESET_CNT,
        TEST_SH,
        SLIP,
        HOLDOFF
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock_32b.sv
// Clause 49 style block-lock controller for the 32-bit RX PCS path.
// Counts sync headers on even gearbox words and requests 1-bit slips until lock is found.
module rx_block_lock_32b
    import rx_pcs_pkg::*;
#(
    parameter int SH_WINDOW    = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_HOLDOFF = 66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ctrl_in,
    input  logic       en_in,
    input  logic       even_in,
    output logic       slip,
    output logic       block_lock,
    output logic [7:0] slip_cnt
);

    localparam logic [6:0] WINDOW_C  = 7'(SH_WINDOW);
    localparam logic [4:0] INVLD_C   = 5'(SH_INVLD_MAX);
    localparam logic [6:0] HOLDOFF_C = 7'(SLIP_HOLDOFF - 1);

    lock_state_t state, state_nxt;
    logic [6:0]  sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [4:0]  sh_invld_cnt, sh_invld_cnt_nxt, sh_invld_inc;
    logic [6:0]  holdoff_cnt, holdoff_cnt_nxt;
    logic        slip_nxt;
    logic        block_lock_nxt;
    logic [7:0]  slip_cnt_nxt;
    logic        hdr_event;

    assign hdr_event    = en_in & even_in;
    assign sh_cnt_inc   = sh_cnt + 7'd1;
    assign sh_invld_inc = sh_invld_cnt + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOCK_INIT;
            sh_cnt       <= '0;
            sh_invld_cnt <= '0;
            holdoff_cnt  <= '0;
            slip         <= 1'b0;
            block_lock   <= 1'b0;
            slip_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            sh_cnt       <= sh_cnt_nxt;
            sh_invld_cnt <= sh_invld_cnt_nxt;
            holdoff_cnt  <= holdoff_cnt_nxt;
            slip         <= slip_nxt;
            block_lock   <= block_lock_nxt;
            slip_cnt     <= slip_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        sh_cnt_nxt       = sh_cnt;
        sh_invld_cnt_nxt = sh_invld_cnt;
        holdoff_cnt_nxt  = holdoff_cnt;
        slip_nxt         = 1'b0;
        block_lock_nxt   = block_lock;
        slip_cnt_nxt     = slip_cnt;

        case (state)
            LOCK_INIT: begin
                block_lock_nxt = 1'b0;
                state_nxt      = RESET_CNT;
            end
            RESET_CNT: begin
                sh_cnt_nxt       = '0;
                sh_invld_cnt_nxt = '0;
                state_nxt        = TEST_SH;
            end
            TEST_SH: begin
                if (hdr_event) begin
                    sh_cnt_nxt = sh_cnt_inc;
                    if (sh_is_valid(ctrl_in)) begin
                        // A clean window grants lock; a window with a few errors only keeps it.
                        if (sh_cnt_inc == WINDOW_C) begin
                            if (sh_invld_cnt == 5'd0) begin
                                block_lock_nxt = 1'b1;
                            end
                            state_nxt = RESET_CNT;
                        end
                    end else begin
                        sh_invld_cnt_nxt = sh_invld_inc;
                        if ((sh_invld_inc == INVLD_C) || !block_lock) begin
                            state_nxt = SLIP;
                        end else if (sh_cnt_inc == WINDOW_C) begin
                            state_nxt = RESET_CNT;
                        end
                    end
                end
            end
            SLIP: begin
                block_lock_nxt  = 1'b0;
                slip_nxt        = 1'b1;
                holdoff_cnt_nxt = HOLDOFF_C;
                if (slip_cnt != 8'hFF) begin
                    slip_cnt_nxt = slip_cnt + 8'd1;
                end
                state_nxt = HOLDOFF;
            end
            HOLDOFF: begin
                // Headers here still carry the old alignment, so they are not tested.
                if (holdoff_cnt == 7'd0) begin
                    state_nxt = RESET_CNT;
                end else begin
                    holdoff_cnt_nxt = holdoff_cnt - 7'd1;
                end
            end
            default: begin
                state_nxt = LOCK_INIT;
            end
        endcase
    end

endmodule
